// File: rtl/iq_unpack.sv
// Byte-stream to I/Q deserializer: gathers four little-endian bytes per pair,
// sign-extends and scales each 16-bit component, and writes both FIFOs together.
//
// state    | meaning
// S_GATHER | popping input bytes into slot r_idx (0..3)
// S_WRITE  | I/Q words formed, waiting for both output FIFOs to have room
module iq_unpack #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  out_wr_en,
  input  logic                  i_out_full,
  input  logic                  q_out_full,
  output logic [31:0]           sample_count
);

  localparam logic [0:0] S_GATHER = 1'b0;
  localparam logic [0:0] S_WRITE  = 1'b1;

  logic [0:0]            r_state;
  logic [1:0]            r_idx;
  logic [7:0]            r_byte0;
  logic [7:0]            r_byte1;
  logic [7:0]            r_byte2;
  logic [DATA_WIDTH-1:0] r_i;
  logic [DATA_WIDTH-1:0] r_q;
  logic [31:0]           r_count;

  logic                  w_rd;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_i_ext;
  logic [DATA_WIDTH-1:0] w_q_ext;

  // Strobes are masked while reset is held so neither FIFO is touched in reset.
  assign w_rd = reset & (r_state == S_GATHER) & ~in_empty;
  assign w_wr = reset & (r_state == S_WRITE) & ~i_out_full & ~q_out_full;

  // Q high byte is taken straight from the FIFO head on the capturing cycle.
  assign w_i_ext = {{(DATA_WIDTH-16){r_byte1[7]}}, r_byte1, r_byte0};
  assign w_q_ext = {{(DATA_WIDTH-16){in_dout[7]}}, in_dout, r_byte2};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_GATHER;
      r_idx   <= 2'd0;
      r_byte0 <= 8'h00;
      r_byte1 <= 8'h00;
      r_byte2 <= 8'h00;
      r_i     <= '0;
      r_q     <= '0;
      r_count <= 32'd0;
    end else begin
      case (r_state)
        S_GATHER: begin
          if (w_rd) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_byte0 <= in_dout;
              2'd1: r_byte1 <= in_dout;
              2'd2: r_byte2 <= in_dout;
              default: begin
                r_i     <= w_i_ext << QUANT_BITS;
                r_q     <= w_q_ext << QUANT_BITS;
                r_state <= S_WRITE;
              end
            endcase
          end
        end
        default: begin
          if (w_wr) begin
            r_count <= r_count + 32'd1;
            r_state <= S_GATHER;
          end
        end
      endcase
    end
  end

  assign in_rd_en     = w_rd;
  assign out_wr_en    = w_wr;
  assign i_out        = r_i;
  assign q_out        = r_q;
  assign sample_count = r_count;

endmodule

// File: tb/tb_iq_unpack.sv
// Scoreboard bench for iq_unpack: a byte-queue input FIFO model feeds the DUT,
// expected I/Q words are queued at stimulus time and checked on each write.
module tb_iq_unpack;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_dout = 8'h00;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [31:0] i_out;
  logic [31:0] q_out;
  logic        out_wr_en;
  logic        i_out_full = 1'b0;
  logic        q_out_full = 1'b0;
  logic [31:0] sample_count;

  always #5 clock = ~clock;

  iq_unpack #(.DATA_WIDTH(32), .QUANT_BITS(10)) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .i_out(i_out), .q_out(q_out), .out_wr_en(out_wr_en),
    .i_out_full(i_out_full), .q_out_full(q_out_full), .sample_count(sample_count)
  );

  logic [7:0]  bq[$];
  logic [31:0] eq_i[$];
  logic [31:0] eq_q[$];
  int checks = 0, passed = 0;
  int rd_cnt = 0, wr_cnt = 0, cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0;
  bit rd_fire = 0, force_empty = 0, force_qfull = 0, rand_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Input FIFO model and output full flags, updated just after each rising edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (rd_fire && bq.size() > 0) void'(bq.pop_front());
    rd_fire = 0;
    in_empty   = (bq.size() == 0) || force_empty || (rand_mode && $urandom_range(0, 3) == 0);
    in_dout    = (bq.size() > 0) ? bq[0] : 8'h00;
    i_out_full = rand_mode && ($urandom_range(0, 4) == 0);
    q_out_full = force_qfull || (rand_mode && $urandom_range(0, 4) == 0);
  end

  // Monitor: pops the scoreboard whenever the DUT writes the I/Q FIFOs.
  always @(negedge clock) begin
    if (reset) begin
      if (in_rd_en) begin
        rd_fire = 1;
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (out_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        check("exp_avail", 32'(eq_i.size() != 0), 32'd1);
        if (eq_i.size() != 0) begin
          check("i_out", i_out, eq_i.pop_front());
          check("q_out", q_out, eq_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [31:0] deq(input logic [15:0] s);
    return {{16{s[15]}}, s} << 10;
  endfunction

  task automatic push_sample(input logic [15:0] iv, input logic [15:0] qv,
                             input logic [31:0] ei, input logic [31:0] eqv);
    bq.push_back(iv[7:0]);
    bq.push_back(iv[15:8]);
    bq.push_back(qv[7:0]);
    bq.push_back(qv[15:8]);
    eq_i.push_back(ei);
    eq_q.push_back(eqv);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((eq_i.size() != 0 || bq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  task automatic wait_reads(input int target, input int budget, input string name);
    int n = 0;
    while (rd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_reads_in_time"}, 32'(rd_cnt >= target), 32'd1);
  endtask

  int base_r, base_w;
  logic [15:0] ri, rq;

  initial begin
    // Reset state, with bytes already waiting at the input.
    push_sample(16'h1234, 16'hABCD, 32'h0048D000, 32'hFEAF3400);
    tick(); tick(); tick();
    check("rst_in_rd_en", 32'(in_rd_en), 32'd0);
    check("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_i_out", i_out, 32'd0);
    check("rst_q_out", q_out, 32'd0);
    check("rst_sample_count", sample_count, 32'd0);
    reset = 1'b1;

    // Single sample, no stalls.
    drain(50, "single");
    check("single_latency", 32'(last_wr_cyc - last_rd_cyc), 32'd1);
    check("single_one_write", 32'(wr_cnt), 32'd1);
    check("single_count", sample_count, 32'd1);

    // Extremes.
    push_sample(16'h7FFF, 16'h8000, 32'h01FFFC00, 32'hFE000000);
    drain(50, "extreme");
    check("extreme_count", sample_count, 32'd2);

    // Back-pressure on Q FIFO right after the 4th byte.
    force_qfull = 1;
    base_r = rd_cnt;
    push_sample(16'h0001, 16'hFFFF, 32'h00000400, 32'hFFFFFC00);
    push_sample(16'h0100, 16'hFF00, 32'h00040000, 32'hFFFC0000);
    push_sample(16'h4000, 16'hC000, 32'h01000000, 32'hFF000000);
    wait_reads(base_r + 4, 50, "bp");
    for (int k = 0; k < 6; k++) begin
      check("bp_no_write", 32'(out_wr_en), 32'd0);
      check("bp_no_read", 32'(in_rd_en), 32'd0);
      check("bp_i_hold", i_out, 32'h00000400);
      check("bp_q_hold", q_out, 32'hFFFFFC00);
      tick();
    end
    force_qfull = 0;
    tick();
    check("bp_release_write", 32'(out_wr_en), 32'd1);
    drain(100, "bp");
    check("bp_count", sample_count, 32'd5);
    check("bp_reads", 32'(rd_cnt - base_r), 32'd12);

    // Input starvation between byte1 and byte2.
    base_r = rd_cnt;
    bq.push_back(8'h78);
    bq.push_back(8'h56);
    wait_reads(base_r + 2, 50, "starve");
    force_empty = 1;
    bq.push_back(8'h21);
    bq.push_back(8'h43);
    eq_i.push_back(32'h0159E000);
    eq_q.push_back(32'h010C8400);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("starve_no_read", 32'(rd_cnt - base_r), 32'd2);
    end
    force_empty = 0;
    drain(50, "starve");
    check("starve_count", sample_count, 32'd6);
    check("starve_reads", 32'(rd_cnt - base_r), 32'd4);

    // Reset after two bytes of a sample.
    base_r = rd_cnt;
    bq.push_back(8'h11);
    bq.push_back(8'h22);
    wait_reads(base_r + 2, 50, "midrst");
    reset = 1'b0;
    tick(); tick();
    check("midrst_count_cleared", sample_count, 32'd0);
    reset = 1'b1;
    push_sample(16'h0003, 16'hFFFD, 32'h00000C00, 32'hFFFFF400);
    drain(50, "midrst");
    check("midrst_count", sample_count, 32'd1);

    // Streaming with random empty/full stalls.
    rand_mode = 1;
    base_r = rd_cnt;
    base_w = wr_cnt;
    for (int k = 0; k < 1000; k++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      push_sample(ri, rq, deq(ri), deq(rq));
    end
    drain(40000, "stream");
    rand_mode = 0;
    check("stream_count", sample_count, 32'd1001);
    check("stream_writes", 32'(wr_cnt - base_w), 32'd1000);
    check("stream_reads", 32'(rd_cnt - base_r), 32'd4000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iq_unpack.md
# iq_unpack

Front-end deserializer for the FM radio pipeline. It reads the raw little-endian byte stream of interleaved 16-bit I/Q samples from the input byte FIFO, sign-extends and dequantizes each component, and writes matched 32-bit I and Q words into the `i_in_fifo` and `q_in_fifo` of the radio top level. One I/Q pair is written per four bytes consumed. Both outputs are always written in the same cycle, so the two downstream FIFOs stay in lock-step.

## Interface
- `DATA_WIDTH`, 32, width of the dequantized output words.
- `QUANT_BITS`, 10, left-shift applied after sign extension (dequantization scale 2^QUANT_BITS).
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_dout`  in  8  byte at the head of the input FIFO; first-word-fall-through, valid whenever `in_empty`=0.
- `in_empty`  in  1  input byte FIFO empty.
- `in_rd_en`  out  1  pops the input byte FIFO; combinational.
- `i_out`  out  DATA_WIDTH  dequantized I sample (din of I FIFO).
- `q_out`  out  DATA_WIDTH  dequantized Q sample (din of Q FIFO).
- `out_wr_en`  out  1  write strobe shared by the I and Q FIFOs; combinational.
- `i_out_full`  in  1  I FIFO full.
- `q_out_full`  in  1  Q FIFO full.
- `sample_count`  out  32  number of I/Q pairs written since reset; wraps 0xFFFFFFFF -> 0.

## Operation
- Byte order per sample: byte0 = I[7:0], byte1 = I[15:8], byte2 = Q[7:0], byte3 = Q[15:8].
- FSM states:
  - GATHER: holds a 2-bit byte index `idx`.
    - `in_rd_en` = (state==GATHER) & ~`in_empty`.
    - On each cycle with `in_rd_en`=1, `in_dout` is stored into byte slot `idx` and `idx` increments.
    - When `idx`==3 and the read fires, go to WRITE and reset `idx` to 0.
  - WRITE:
    - `out_wr_en` = (state==WRITE) & ~`i_out_full` & ~`q_out_full`.
    - On a cycle with `out_wr_en`=1: return to GATHER and increment `sample_count`.
    - Otherwise hold WRITE with the outputs stable.
- Arithmetic, computed into registers when the 4th byte is captured:
  - `i_out` = sign_extend({byte1,byte0}) <<< QUANT_BITS, truncated to DATA_WIDTH.
  - `q_out` = the same operation on {byte3,byte2}.
- `i_out`/`q_out` hold their value until the next sample is formed.
- No read from the input FIFO occurs in WRITE, so no byte is lost under output back-pressure.
- A partially gathered sample (idx 1..3) waits indefinitely on `in_empty`. Bytes already gathered are retained.
- If either output FIFO is full, neither is written (no split writes).
- Reset mid-sample: any partially gathered bytes are discarded, and the next byte read after reset is treated as byte0.

## Timing
- Reset values: state=GATHER, idx=0, `i_out`=0, `q_out`=0, `sample_count`=0.
- During reset, `out_wr_en`=0 and `in_rd_en`=0.
- Combinational outputs:
  - `in_rd_en` depends only on the state and `in_empty`.
  - `out_wr_en` depends only on the state and the two full flags.
  - There is no combinational path from `in_dout` to any output.
- Latency: if the 4th byte is read in cycle N, `i_out`/`q_out` are valid and `out_wr_en` can assert in cycle N+1.
- Throughput: at best 5 cycles per I/Q pair (4 reads plus 1 write); stalls on empty input or full output add cycles 1:1.
- `sample_count` updates on the clock edge that ends an `out_wr_en` cycle.
- Simultaneous events: `in_empty` deasserting while in WRITE has no effect until the state returns to GATHER.
- Full flags deasserting in the same cycle the state enters WRITE permit the write in that cycle.

## Test plan
- Single sample: feed bytes 0x34,0x12,0xCD,0xAB with no stalls -> exactly one `out_wr_en` pulse, 1 cycle after the 4th read; `i_out`=0x0048D000, `q_out`=0xFEAF3400; `sample_count`=1.
- Extremes: I=0x7FFF, Q=0x8000 -> `i_out`=0x01FFFC00, `q_out`=0xFE000000.
- Back-pressure: hold `q_out_full`=1 for 6 cycles after the 4th byte -> `out_wr_en`=0 and `in_rd_en`=0 throughout, outputs stable; the write fires in the first cycle after release; no bytes are dropped across the next 3 samples.
- Input starvation: assert `in_empty` between byte1 and byte2 for 10 cycles -> correct sample assembled, no extra reads, `sample_count` increments once.
- Reset mid-sample: assert `reset`=0 after 2 bytes, release, then stream 4 fresh bytes -> the output equals the fresh sample only; `sample_count`=1.
- Streaming: 1000 random samples with random empty/full stalls -> the output sequence matches a software model; `sample_count`=1000; the I and Q FIFOs receive equal write counts.
